nbit_adder: RTL and testbench

//  Registered N-bit two's-complement add/subtract unit.

---
 rtl/nbit_adder_if.sv | 30 +++
 rtl/nbit_adder.sv | 83 ++++++++
 tb/tb_nbit_adder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nbit_adder_if.sv
// Operand/result bundle for nbit_adder. The master drives operands and
// receives registered results; the slave is the adder itself.
interface nbit_adder_if #(
   parameter int N = 8
);
   // in_valid qualifies a/b for the edge it is sampled on. There is no ready:
   // the slave accepts every cycle, and out_valid is high for exactly the
   // cycle after each accepted pair.
   logic         in_valid;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic [N-1:0] sum;
   logic [N-1:0] diff;
   logic [N-1:0] tempo;
   logic         carry;
   logic         borrow;
   logic         ovf_add;
   logic         ovf_sub;

   modport master (
      output in_valid, a, b,
      input  out_valid, sum, diff, tempo, carry, borrow, ovf_add, ovf_sub
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, sum, diff, tempo, carry, borrow, ovf_add, ovf_sub
   );
endinterface

// File: rtl/nbit_adder.sv
// Registered N-bit add/subtract/negate built from ripple-carry full-adder chains.
// Define NBIT_ADDER_SAT_EN for unsigned saturation of sum/diff.
module nbit_adder #(
   parameter int N = 8
) (
   input  logic        clk,
   input  logic        rst,
   nbit_adder_if.slave bus
);

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
      full_add = {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
   endfunction

   logic [N-1:0] add_s;
   logic [N-1:0] sub_s;
   logic [N-1:0] neg_s;
   logic         add_c;
   logic         sub_c;
   logic         neg_c;
   logic         ovf_add_raw;
   logic         ovf_sub_raw;
   logic [N-1:0] sum_next;
   logic [N-1:0] diff_next;

   // Carries walk through a loop-local chain so each stage sees the previous one.
   always_comb begin
      add_s = '0;
      sub_s = '0;
      neg_s = '0;
      add_c = 1'b0;
      sub_c = 1'b1;
      neg_c = 1'b1;
      for (int i = 0; i < N; i++) begin
         {add_c, add_s[i]} = full_add(bus.a[i], bus.b[i], add_c);
         {sub_c, sub_s[i]} = full_add(bus.a[i], ~bus.b[i], sub_c);
         {neg_c, neg_s[i]} = full_add(1'b0, ~bus.b[i], neg_c);
      end
   end

   always_comb begin
      ovf_add_raw = (bus.a[N-1] == bus.b[N-1]) && (add_s[N-1] != bus.a[N-1]);
      ovf_sub_raw = (bus.a[N-1] != bus.b[N-1]) && (sub_s[N-1] != bus.a[N-1]);
   end

`ifdef NBIT_ADDER_SAT_EN
   // Flags still describe the wrapped results; only sum/diff are clamped.
   always_comb begin
      sum_next  = add_c  ? '1 : add_s;
      diff_next = !sub_c ? '0 : sub_s;
   end
`else
   always_comb begin
      sum_next  = add_s;
      diff_next = sub_s;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.sum       <= '0;
         bus.diff      <= '0;
         bus.tempo     <= '0;
         bus.carry     <= 1'b0;
         bus.borrow    <= 1'b0;
         bus.ovf_add   <= 1'b0;
         bus.ovf_sub   <= 1'b0;
      end else if (bus.in_valid) begin
         bus.out_valid <= 1'b1;
         bus.sum       <= sum_next;
         bus.diff      <= diff_next;
         bus.tempo     <= neg_s;
         bus.carry     <= add_c;
         bus.borrow    <= ~sub_c;
         bus.ovf_add   <= ovf_add_raw;
         bus.ovf_sub   <= ovf_sub_raw;
      end else begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nbit_adder.sv
// Directed bench for nbit_adder (N=8): arithmetic model, expected queue,
// per-cycle compare and literal pins on the model.
module tb_nbit_adder;

   localparam int N = 8;
   localparam int W = 1 + 3 * N + 4;

   logic clk;
   logic rst;
   int   check_cnt = 0;
   int   pass_cnt  = 0;

   logic [W-1:0] exp_q[$];
   logic [W-2:0] model_hold;

   nbit_adder_if #(.N(N)) bus ();

   nbit_adder #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Spec-level model: plain integer arithmetic, signed ranges for overflow.
   function automatic logic [W-1:0] model(input int a, input int b);
      int s, d, sa, sb, sum_v, diff_v, tempo_v;
      logic carry_v, borrow_v, oa, os;
      s  = a + b;
      d  = a - b;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      sum_v    = s % 256;
      diff_v   = (d + 256) % 256;
      tempo_v  = (256 - b) % 256;
      carry_v  = (s > 255);
      borrow_v = (a < b);
      oa = ((sa + sb) > 127) || ((sa + sb) < -128);
      os = ((sa - sb) > 127) || ((sa - sb) < -128);
`ifdef NBIT_ADDER_SAT_EN
      if (carry_v)  sum_v  = 255;
      if (borrow_v) diff_v = 0;
`endif
      model = {1'b1, sum_v[7:0], diff_v[7:0], tempo_v[7:0], carry_v, borrow_v, oa, os};
   endfunction

   function automatic logic [W-1:0] dut_vec();
      dut_vec = {bus.out_valid, bus.sum, bus.diff, bus.tempo,
                 bus.carry, bus.borrow, bus.ovf_add, bus.ovf_sub};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      check_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // driver: inputs change on the falling edge, expectation queued per cycle
   task automatic drive(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
      logic [W-1:0] m;
      @(negedge clk);
      rst          = r;
      bus.in_valid = v;
      bus.a        = a;
      bus.b        = b;
      m = model(int'(a), int'(b));
      if (r) begin
         model_hold = '0;
         exp_q.push_back('0);
      end else if (v) begin
         model_hold = m[W-2:0];
         exp_q.push_back({1'b1, model_hold});
      end else begin
         exp_q.push_back({1'b0, model_hold});
      end
   endtask

   // scoreboard compare, 2 time units after each rising edge
   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) check("cycle", dut_vec(), exp_q.pop_front());
   end

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      model_hold   = '0;

      // literal pins on the model itself
      check("pin_2_2",    model(2, 2),    {1'b1, 8'd4,   8'd0,   8'd254, 4'b0000});
      check("pin_33_10",  model(33, 10),  {1'b1, 8'd43,  8'd23,  8'd246, 4'b0000});
      check("pin_127_1",  model(127, 1),  {1'b1, 8'd128, 8'd126, 8'd255, 4'b0010});
      check("pin_128_1",  model(128, 1),  {1'b1, 8'd129, 8'd127, 8'd255, 4'b0001});
`ifdef NBIT_ADDER_SAT_EN
      check("pin_49_190", model(49, 190), {1'b1, 8'd239, 8'd0,   8'd66,  4'b0100});
      check("pin_255_1",  model(255, 1),  {1'b1, 8'd255, 8'd254, 8'd255, 4'b1000});
`else
      check("pin_49_190", model(49, 190), {1'b1, 8'd239, 8'd115, 8'd66,  4'b0100});
      check("pin_255_1",  model(255, 1),  {1'b1, 8'd0,   8'd254, 8'd255, 4'b1000});
`endif

      // reset state, then the directed vectors back-to-back
      drive(1'b1, 1'b0, 8'd0,   8'd0);
      drive(1'b1, 1'b0, 8'd0,   8'd0);
      drive(1'b0, 1'b1, 8'd2,   8'd2);
      drive(1'b0, 1'b1, 8'd33,  8'd10);
      drive(1'b0, 1'b1, 8'd49,  8'd190);
      drive(1'b0, 1'b1, 8'd127, 8'd1);
      drive(1'b0, 1'b1, 8'd255, 8'd1);
      drive(1'b0, 1'b1, 8'd128, 8'd1);
      drive(1'b0, 1'b1, 8'd0,   8'd0);
      drive(1'b0, 1'b1, 8'd0,   8'd128);
      drive(1'b0, 1'b1, 8'd200, 8'd200);
      drive(1'b0, 1'b1, 8'd128, 8'd128);
      drive(1'b0, 1'b1, 8'd255, 8'd255);
      drive(1'b0, 1'b1, 8'd1,   8'd255);
      // idle: results hold, out_valid drops
      drive(1'b0, 1'b0, 8'd77,  8'd3);
      drive(1'b0, 1'b0, 8'd9,   8'd99);
      drive(1'b0, 1'b1, 8'd100, 8'd27);
      // reset wins over in_valid, then idle holds the cleared values
      drive(1'b1, 1'b1, 8'd250, 8'd13);
      drive(1'b0, 1'b0, 8'd5,   8'd6);
      drive(1'b0, 1'b1, 8'd64,  8'd192);
      drive(1'b0, 1'b1, 8'd192, 8'd64);
      drive(1'b0, 1'b0, 8'd0,   8'd0);

      // bounded drain of outstanding expectations
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check_cnt++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
